// File: rtl/multicycle_seq_pkg.sv
// Shared encodings for the microRISC multi-cycle sequencer: states, opcodes,
// PC-source and write-back selects.
package multicycle_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6
  } state_e;

  localparam logic [3:0] OpR    = 4'h0;
  localparam logic [3:0] OpAddi = 4'h1;
  localparam logic [3:0] OpLw   = 4'h2;
  localparam logic [3:0] OpSw   = 4'h3;
  localparam logic [3:0] OpBeq  = 4'h4;
  localparam logic [3:0] OpBne  = 4'h5;
  localparam logic [3:0] OpJ    = 4'h6;
  localparam logic [3:0] OpJal  = 4'h7;
  localparam logic [3:0] OpJr   = 4'h8;

  localparam logic [1:0] PcSrcInc    = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;
  localparam logic [1:0] PcSrcRs     = 2'd3;

  localparam logic [1:0] WbSelAlu  = 2'd0;
  localparam logic [1:0] WbSelMem  = 2'd1;
  localparam logic [1:0] WbSelLink = 2'd2;

endpackage

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake timeout,
// sticky error flags and a retired-instruction counter.
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_req,
  input  logic [3:0]       opcode,
  input  logic             cond_true,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal,
  output logic             bus_err
);

  localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [3:0]      op_q;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_last;
  logic            done;
  logic            set_illegal, set_bus_err;

  assign state    = state_q;
  assign tmo_last = (tmo_q == TmoW'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    tmo_d       = '0;
    done        = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PcSrcInc;
    reg_we      = 1'b0;
    wb_sel      = WbSelAlu;
    retire      = 1'b0;

    case (state_q)
      StIdle: if (run) state_d = StFetch;
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end else if (tmo_last) begin
          state_d     = StTrap;
          set_bus_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDecode: begin
        case (opcode)
          OpJ: begin
            pc_we  = 1'b1;
            pc_src = PcSrcJump;
            done   = 1'b1;
          end
          OpJal: begin
            pc_we  = 1'b1;
            pc_src = PcSrcJump;
            reg_we = 1'b1;
            wb_sel = WbSelLink;
            done   = 1'b1;
          end
          OpJr: begin
            pc_we  = 1'b1;
            pc_src = PcSrcRs;
            done   = 1'b1;
          end
          OpR, OpAddi, OpLw, OpSw, OpBeq, OpBne: state_d = StExec;
          default: begin
            state_d     = StTrap;
            set_illegal = 1'b1;
          end
        endcase
      end
      StExec: begin
        case (op_q)
          OpBeq, OpBne: begin
            pc_we  = cond_true;
            pc_src = PcSrcBranch;
            done   = 1'b1;
          end
          OpLw, OpSw: state_d = StMem;
          default:    state_d = StWb;
        endcase
      end
      StMem: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op_q == OpSw);
        if (mem_ready) begin
          if (op_q == OpLw) state_d = StWb;
          else              done    = 1'b1;
        end else if (tmo_last) begin
          state_d     = StTrap;
          set_bus_err = 1'b1;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWb: begin
        reg_we = 1'b1;
        wb_sel = (op_q == OpLw) ? WbSelMem : WbSelAlu;
        done   = 1'b1;
      end
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase

    // Instruction boundary: retire and decide whether to keep running.
    if (done) begin
      retire  = 1'b1;
      state_d = (halt_req || !run) ? StIdle : StFetch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      op_q        <= '0;
      tmo_q       <= '0;
      retired_cnt <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (state_q == StDecode) op_q <= opcode;
      if (retire)              retired_cnt <= retired_cnt + CNT_W'(1);
      if (set_illegal)         illegal <= 1'b1;
      if (set_bus_err)         bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq; expected per-cycle state and control vectors are hand-derived.
module tb_multicycle_seq;
  import multicycle_seq_pkg::*;

  localparam int unsigned CntW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic            halt_req = 1'b0;
  logic [3:0]      opcode = 4'h0;
  logic            cond_true = 1'b0;
  logic            mem_ready = 1'b0;
  logic            mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, retire;
  logic [1:0]      pc_src, wb_sel;
  logic [2:0]      state;
  logic [CntW-1:0] retired_cnt;
  logic            illegal, bus_err;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_seq #(.MEM_TIMEOUT(15), .CNT_W(CntW)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .halt_req   (halt_req),
    .opcode     (opcode),
    .cond_true  (cond_true),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .ir_we      (ir_we),
    .pc_we      (pc_we),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .wb_sel     (wb_sel),
    .state      (state),
    .retire     (retire),
    .retired_cnt(retired_cnt),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel, retire}
  logic [10:0] act_ctl;
  assign act_ctl = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel, retire};

  function automatic logic [10:0] ctl(input logic mrq, input logic mwe, input logic asl,
                                      input logic irw, input logic pcw, input logic [1:0] psrc,
                                      input logic rwe, input logic [1:0] wsel, input logic ret);
    return {mrq, mwe, asl, irw, pcw, psrc, rwe, wsel, ret};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check the current cycle with the inputs already applied, then advance one clock.
  task automatic cyc(input string tag, input state_e st, input logic [10:0] exp_ctl);
    #1;
    check_eq({tag, ".state"}, 32'(state), 32'(st));
    check_eq({tag, ".ctl"}, 32'(act_ctl), 32'(exp_ctl));
    @(posedge clk);
    #2;
  endtask

  logic [10:0] f_ok, m_wait, z;

  initial begin
    f_ok   = ctl(1, 0, 0, 1, 1, 2'd0, 0, 2'd0, 0);
    m_wait = ctl(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 0);
    z      = '0;

    repeat (2) @(posedge clk);
    #2;
    #1;
    check_eq("rst.state", 32'(state), 32'(StIdle));
    check_eq("rst.ctl", 32'(act_ctl), 32'(0));
    check_eq("rst.cnt", 32'(retired_cnt), 32'(0));
    check_eq("rst.flags", 32'({illegal, bus_err}), 32'(0));

    rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = OpR;
    cyc("idle", StIdle, z);

    // ADD: 4 cycles, reg_we and retire only in WB
    cyc("add.f", StFetch, f_ok);
    cyc("add.d", StDecode, z);
    cyc("add.e", StExec, z);
    cyc("add.w", StWb, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 1));
    check_eq("add.cnt", 32'(retired_cnt), 32'(1));

    // LW with 3 wait cycles in MEM
    opcode = OpLw;
    cyc("lw.f", StFetch, f_ok);
    cyc("lw.d", StDecode, z);
    cyc("lw.e", StExec, z);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw.mwait", StMem, m_wait);
    mem_ready = 1'b1;
    cyc("lw.m", StMem, m_wait);
    cyc("lw.w", StWb, ctl(0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 1));
    check_eq("lw.cnt", 32'(retired_cnt), 32'(2));

    // BEQ not taken, then taken
    opcode = OpBeq; cond_true = 1'b0;
    cyc("beq0.f", StFetch, f_ok);
    cyc("beq0.d", StDecode, z);
    cyc("beq0.e", StExec, ctl(0, 0, 0, 0, 0, 2'd1, 0, 2'd0, 1));
    cond_true = 1'b1;
    cyc("beq1.f", StFetch, f_ok);
    cyc("beq1.d", StDecode, z);
    cyc("beq1.e", StExec, ctl(0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 1));
    check_eq("beq.cnt", 32'(retired_cnt), 32'(4));
    cond_true = 1'b0;

    // JAL retires in DECODE, straight back to FETCH
    opcode = OpJal;
    cyc("jal.f", StFetch, f_ok);
    cyc("jal.d", StDecode, ctl(0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 1));
    check_eq("jal.cnt", 32'(retired_cnt), 32'(5));

    // SW with halt_req raised mid-instruction: completes, then IDLE
    opcode = OpSw;
    cyc("sw.f", StFetch, f_ok);
    halt_req = 1'b1;
    cyc("sw.d", StDecode, z);
    cyc("sw.e", StExec, z);
    cyc("sw.m", StMem, ctl(1, 1, 1, 0, 0, 2'd0, 0, 2'd0, 1));
    halt_req = 1'b0;
    check_eq("sw.cnt", 32'(retired_cnt), 32'(6));
    cyc("sw.idle", StIdle, z);

    // J and JR; 8th retirement wraps the 3-bit counter
    opcode = OpJ;
    cyc("j.f", StFetch, f_ok);
    cyc("j.d", StDecode, ctl(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 1));
    opcode = OpJr;
    cyc("jr.f", StFetch, f_ok);
    cyc("jr.d", StDecode, ctl(0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 1));
    check_eq("cnt.wrap", 32'(retired_cnt), 32'(0));

    // FETCH timeout: exactly 15 waiting cycles, then TRAP with bus_err
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check_eq("tmo.buserr_low", 32'(bus_err), 32'(0));
      cyc("tmo.f", StFetch, ctl(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0));
    end
    check_eq("tmo.buserr", 32'(bus_err), 32'(1));
    check_eq("tmo.illegal", 32'(illegal), 32'(0));
    mem_ready = 1'b1;
    cyc("tmo.trap", StTrap, z);
    rst = 1'b1;
    cyc("tmo.trap2", StTrap, z);
    rst = 1'b0;
    #1;
    check_eq("tmo.rst_flags", 32'({illegal, bus_err}), 32'(0));
    check_eq("tmo.rst_cnt", 32'(retired_cnt), 32'(0));

    // Undefined opcode traps; TRAP ignores halt_req and mem_ready
    opcode = 4'hF;
    cyc("ill.idle", StIdle, z);
    cyc("ill.f", StFetch, f_ok);
    cyc("ill.d", StDecode, z);
    check_eq("ill.flag", 32'(illegal), 32'(1));
    halt_req = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ill.trap", StTrap, z);
    halt_req = 1'b0;
    rst = 1'b1;
    cyc("ill.trap_rst", StTrap, z);
    rst = 1'b0;
    #1;
    check_eq("ill.rst_flag", 32'(illegal), 32'(0));

    // Reset mid-instruction abandons it before WB
    opcode = OpR;
    cyc("rmid.idle", StIdle, z);
    cyc("rmid.f", StFetch, f_ok);
    cyc("rmid.d", StDecode, z);
    rst = 1'b1;
    cyc("rmid.e", StExec, z);
    rst = 1'b0; run = 1'b0;
    cyc("rmid.idle2", StIdle, z);
    cyc("rmid.idle3", StIdle, z);
    check_eq("rmid.cnt", 32'(retired_cnt), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
